// File: rtl/id_loop_ctrl_pkg.sv
// id_loop_ctrl_pkg
//   Opcode constants, instruction field positions and the loop-stack entry
//   type. These are shared by the decode-side loop controller and its loop
//   stack.
package id_loop_ctrl_pkg;

  localparam int unsigned LE_PC_W  = 16;
  localparam int unsigned LE_CNT_W = 8;

  // Instruction field positions
  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 27;
  localparam int unsigned TGT_HI = 15;
  localparam int unsigned TGT_LO = 0;
  localparam int unsigned CNT_HI = 23;
  localparam int unsigned CNT_LO = 16;

  localparam logic [4:0] OP_JMP     = 5'h1A;
  localparam logic [4:0] OP_LOOP    = 5'h12;
  localparam logic [4:0] OP_ENDLOOP = 5'h13;

  typedef struct packed {
    logic [LE_PC_W-1:0]  start;
    logic [LE_CNT_W-1:0] cnt;
  } loop_entry;

  function automatic logic [4:0] opcode_of(input logic [31:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/loop_stack.sv
// loop_stack
//   LIFO of LOOP_DEPTH loop_entry records. It holds the loop start address
//   and the number of iterations still to run for each nesting level.
//   Ports:
//     CLOCK_50, reset_n : clock and async active-low reset (clears all entries)
//     push, push_entry  : push a new entry (ignored when full)
//     pop               : drop the top entry (ignored when empty)
//     dec_top           : decrement the top entry's count
//     top               : current top entry ('0 when empty)
//     empty, full       : occupancy flags
//   The caller never asserts push and pop in the same cycle.
module loop_stack
  import id_loop_ctrl_pkg::*;
#(
  parameter int unsigned LOOP_DEPTH = 4
) (
  input  logic      CLOCK_50,
  input  logic      reset_n,
  input  logic      push,
  input  loop_entry push_entry,
  input  logic      pop,
  input  logic      dec_top,
  output loop_entry top,
  output logic      empty,
  output logic      full
);

  localparam int unsigned SP_W  = $clog2(LOOP_DEPTH + 1);
  localparam int unsigned IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

  loop_entry       mem [LOOP_DEPTH];
  logic [SP_W-1:0] sp;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] wr_idx;

  assign top_idx = IDX_W'(sp - 1'b1);
  assign wr_idx  = IDX_W'(sp);
  assign empty   = (sp == '0);
  assign full    = (sp == SP_W'(LOOP_DEPTH));
  assign top     = empty ? '0 : mem[top_idx];

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sp  <= '0;
      mem <= '{default: '0};
    end else if (push && !full) begin
      mem[wr_idx] <= push_entry;
      sp          <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end else if (dec_top && !empty) begin
      mem[top_idx].cnt <= mem[top_idx].cnt - 1'b1;
    end
  end

endmodule

// File: rtl/id_loop_ctrl.sv
// id_loop_ctrl
//   Decode-side partner of the fetch stage. It resolves JMP, LOOP and
//   ENDLOOP locally with a hardware loop stack and redirects fetch. All
//   other instructions go to execute together with their PCs.
//   Ports:
//     CLOCK_50, reset_n : clock and async active-low reset
//     id_instr          : instruction word from fetch
//     fe_pc             : fetch PC; it belongs to the next id_instr word
//     ex_busy           : execute cannot accept this cycle
//     Stall             : freeze fetch (equal to ex_busy)
//     Loop, PC_in       : combinational fetch redirect and its target
//     ex_instr, ex_pc   : instruction and PC forwarded to execute
//     ex_valid          : ex_instr is a real instruction
//     loop_err          : sticky loop-stack overflow/underflow flag
module id_loop_ctrl
  import id_loop_ctrl_pkg::*;
#(
  parameter int unsigned LOOP_DEPTH = 4,
  parameter int unsigned CNT_W      = LE_CNT_W,
  parameter int unsigned PC_W       = LE_PC_W
) (
  input  logic            CLOCK_50,
  input  logic            reset_n,
  input  logic [31:0]     id_instr,
  input  logic [PC_W-1:0] fe_pc,
  input  logic            ex_busy,
  output logic            Stall,
  output logic            Loop,
  output logic [PC_W-1:0] PC_in,
  output logic [31:0]     ex_instr,
  output logic [PC_W-1:0] ex_pc,
  output logic            ex_valid,
  output logic            loop_err
);

  logic [PC_W-1:0]  id_pc;
  logic             sq;
  logic [4:0]       opcode;
  logic             is_jmp, is_loop, is_end, active;
  logic [CNT_W-1:0] loop_cnt;
  loop_entry        push_entry, st_top;
  logic             st_empty, st_full, push, pop, dec_top, err_set;

  assign opcode   = opcode_of(id_instr);
  assign is_jmp   = (opcode == OP_JMP);
  assign is_loop  = (opcode == OP_LOOP);
  assign is_end   = (opcode == OP_ENDLOOP);
  assign loop_cnt = id_instr[CNT_HI:CNT_LO];
  assign Stall    = ex_busy;
  // A word arriving right after a redirect is wrong-path and is never decoded.
  assign active   = !ex_busy && !sq;

  always_comb begin
    push_entry       = '0;
    push_entry.start = id_pc + 1'b1;
    push_entry.cnt   = (loop_cnt == '0) ? LE_CNT_W'(1) : loop_cnt;
  end

  // Gating with reset_n keeps Loop/PC_in at zero while reset is held,
  // whatever fetch presents on id_instr.
  always_comb begin
    Loop    = 1'b0;
    PC_in   = '0;
    push    = 1'b0;
    pop     = 1'b0;
    dec_top = 1'b0;
    err_set = 1'b0;
    if (reset_n && active) begin
      if (is_jmp) begin
        Loop  = 1'b1;
        PC_in = id_instr[TGT_HI:TGT_LO];
      end else if (is_loop) begin
        if (st_full) err_set = 1'b1;
        else         push    = 1'b1;
      end else if (is_end) begin
        if (st_empty) begin
          err_set = 1'b1;
        end else if (st_top.cnt > LE_CNT_W'(1)) begin
          Loop    = 1'b1;
          PC_in   = st_top.start;
          dec_top = 1'b1;
        end else begin
          pop = 1'b1;
        end
      end
    end
  end

  loop_stack #(
    .LOOP_DEPTH (LOOP_DEPTH)
  ) u_loop_stack (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .dec_top    (dec_top),
    .top        (st_top),
    .empty      (st_empty),
    .full       (st_full)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      id_pc    <= '0;
      sq       <= 1'b0;
      ex_instr <= '0;
      ex_pc    <= '0;
      ex_valid <= 1'b0;
      loop_err <= 1'b0;
    end else if (!ex_busy) begin
      id_pc <= fe_pc;
      sq    <= Loop;
      if (err_set) loop_err <= 1'b1;
      if (sq || is_jmp || is_loop || is_end) begin
        ex_valid <= 1'b0;
      end else begin
        ex_instr <= id_instr;
        ex_pc    <= id_pc;
        ex_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_loop_ctrl.sv
// tb_id_loop_ctrl
//   Self-checking bench for id_loop_ctrl. The bench acts as the fetch stage
//   over a 256-word program memory. An architectural interpreter of the
//   program gives the expected stream of forwarded instructions and the
//   expected redirect targets.
module tb_id_loop_ctrl;

  localparam int TB_DEPTH = 4;
  localparam logic [31:0] W_JMP10 = 32'hD100000A;
  localparam logic [31:0] W_LOOP4 = 32'h91040000;
  localparam logic [31:0] W_LOOP2 = 32'h91020000;
  localparam logic [31:0] W_END   = 32'h98000000;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n  = 1'b0;
  logic [31:0] id_instr = '0;
  logic [15:0] fe_pc    = '0;
  logic        ex_busy  = 1'b0;
  logic        Stall, Loop, ex_valid, loop_err;
  logic [15:0] PC_in, ex_pc;
  logic [31:0] ex_instr;

  always #10 CLOCK_50 = ~CLOCK_50;

  id_loop_ctrl #(
    .LOOP_DEPTH (4),
    .CNT_W      (8),
    .PC_W       (16)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .id_instr (id_instr),
    .fe_pc    (fe_pc),
    .ex_busy  (ex_busy),
    .Stall    (Stall),
    .Loop     (Loop),
    .PC_in    (PC_in),
    .ex_instr (ex_instr),
    .ex_pc    (ex_pc),
    .ex_valid (ex_valid),
    .loop_err (loop_err)
  );

  typedef struct {
    logic [15:0] pc;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  typedef struct {
    logic [15:0] start;
    int          cnt;
  } ent_t;

  logic [31:0] imem [256];
  exp_t        exp_q[$];
  logic [15:0] red_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          seen_red, n_emit, watch_hits;
  logic [15:0] watch_pc = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Architectural execution of imem from PC 0. It is preceded by the fetch
  // reset word (opcode 0 at PC 0), which decode forwards as a NOP.
  task automatic build_model(input int steps);
    ent_t        stk[$];
    ent_t        t;
    logic [15:0] pc;
    logic        err;
    logic [31:0] w;
    pc  = '0;
    err = 1'b0;
    exp_q.delete();
    red_q.delete();
    exp_q.push_back('{16'h0, 32'h0, 1'b0});
    for (int s = 0; s < steps; s++) begin
      w = imem[pc[7:0]];
      if (w[31:27] == 5'h1A) begin
        red_q.push_back(w[15:0]);
        pc = w[15:0];
      end else if (w[31:27] == 5'h12) begin
        if (stk.size() >= TB_DEPTH) err = 1'b1;
        else begin
          t.start = pc + 16'd1;
          t.cnt   = (w[23:16] == 8'd0) ? 1 : int'(w[23:16]);
          stk.push_back(t);
        end
        pc = pc + 16'd1;
      end else if (w[31:27] == 5'h13) begin
        if (stk.size() == 0) begin
          err = 1'b1;
          pc  = pc + 16'd1;
        end else begin
          t = stk[stk.size()-1];
          if (t.cnt > 1) begin
            t.cnt = t.cnt - 1;
            stk[stk.size()-1] = t;
            red_q.push_back(t.start);
            pc = t.start;
          end else begin
            void'(stk.pop_back());
            pc = pc + 16'd1;
          end
        end
      end else begin
        exp_q.push_back('{pc, w, err});
        pc = pc + 16'd1;
      end
    end
  endtask

  task automatic load_default();
    for (int i = 0; i < 256; i++) imem[i] = {5'h01, 11'h000, 16'(i)};
  endtask

  task automatic load_random();
    logic [31:0] w;
    int unsigned r;
    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(99);
      w = $urandom;
      if (r < 4) begin
        w[31:27] = 5'h1A;
        w[15:8]  = 8'h00;
      end else if (r < 12) begin
        w[31:27] = 5'h12;
        w[23:16] = 8'($urandom_range(3));
      end else if (r < 22) begin
        w[31:27] = 5'h13;
      end else if (w[31:27] inside {5'h1A, 5'h12, 5'h13}) begin
        w[31:27] = 5'h01;
      end
      imem[i] = w;
    end
  endtask

  // Ends just after a falling edge with reset released and fetch at PC 0.
  task automatic do_reset();
    @(negedge CLOCK_50);
    reset_n  = 1'b0;
    ex_busy  = 1'b0;
    id_instr = W_JMP10;
    fe_pc    = '0;
    #1;
    check("rst_Loop", Loop, 1'b0);
    check("rst_PC_in", PC_in, 16'h0);
    @(posedge CLOCK_50);
    #1;
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_ex_instr", ex_instr, 32'h0);
    check("rst_ex_pc", ex_pc, 16'h0);
    check("rst_loop_err", loop_err, 1'b0);
    id_instr = '0;
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic run(input int cycles, input int busy_pct, input bit stall_end, input int stop_red);
    logic [15:0] fe_r, pcin_s, h_pc;
    logic [31:0] h_instr;
    logic        stall_s, loop_s, h_valid, h_err;
    int          busy_left;
    bit          stall_done;
    exp_t        e;
    fe_r       = '0;
    seen_red   = 0;
    n_emit     = 0;
    watch_hits = 0;
    busy_left  = 0;
    stall_done = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      stall_s = Stall;
      loop_s  = Loop;
      pcin_s  = PC_in;
      h_instr = ex_instr;
      h_pc    = ex_pc;
      h_valid = ex_valid;
      h_err   = loop_err;
      check("stall_eq_busy", Stall, ex_busy);
      if (ex_busy) check("loop_while_stall", Loop, 1'b0);
      if (loop_s) begin
        seen_red++;
        if (red_q.size() == 0) check("extra_redirect", loop_s, 1'b0);
        else                   check("redirect_target", pcin_s, red_q.pop_front());
      end
      if (stop_red > 0 && seen_red == stop_red) break;
      @(posedge CLOCK_50);
      #1;
      if (stall_s) begin
        check("hold_ex_instr", ex_instr, h_instr);
        check("hold_ex_pc", ex_pc, h_pc);
        check("hold_ex_valid", ex_valid, h_valid);
        check("hold_loop_err", loop_err, h_err);
      end else if (ex_valid) begin
        n_emit++;
        if (ex_pc == watch_pc) watch_hits++;
        if (exp_q.size() == 0) check("extra_ex_valid", ex_valid, 1'b0);
        else begin
          e = exp_q.pop_front();
          check("ex_pc", ex_pc, e.pc);
          check("ex_instr", ex_instr, e.instr);
          check("ex_loop_err", loop_err, e.err);
        end
      end
      if (!stall_s) begin
        id_instr = imem[fe_r[7:0]];
        fe_r     = loop_s ? pcin_s : fe_r + 16'd1;
        fe_pc    = fe_r;
      end
      if (busy_left > 0) busy_left--;
      if (stall_end && !stall_done && !stall_s && id_instr[31:27] == 5'h13) begin
        busy_left  = 3;
        stall_done = 1'b1;
      end
      ex_busy = stall_end ? (busy_left > 0) : ($urandom_range(99) < busy_pct);
      @(negedge CLOCK_50);
    end
  endtask

  initial begin
    // Straight-line code
    load_default();
    imem[5] = 32'h23410000;
    imem[6] = 32'h23810000;
    build_model(400);
    do_reset();
    run(12, 0, 1'b0, 0);
    check("straight_redirects", seen_red, 0);
    check("straight_emitted", n_emit, 12);

    // JMP with a squashed wrong-path word
    load_default();
    imem[1] = W_JMP10;
    build_model(400);
    do_reset();
    run(10, 0, 1'b0, 0);
    check("jmp_redirects", seen_red, 1);

    // Counted loop, a 3-cycle stall on the first ENDLOOP, then ENDLOOP on an empty stack
    load_default();
    imem[13] = W_LOOP4;
    imem[30] = W_END;
    imem[40] = W_END;
    watch_pc = 16'd14;
    build_model(600);
    do_reset();
    run(140, 0, 1'b1, 0);
    check("loop_redirects", seen_red, 3);
    check("loop_body_passes", watch_hits, 4);
    check("loop_empty_after", loop_err, 1'b1);

    // ENDLOOP with an empty stack
    load_default();
    imem[0] = W_END;
    build_model(400);
    do_reset();
    run(10, 0, 1'b0, 0);
    check("underflow_err", loop_err, 1'b1);
    check("underflow_redirects", seen_red, 0);

    // Five nested LOOPs with a 4-deep stack
    load_default();
    for (int i = 0; i < 5; i++) imem[i] = W_LOOP2;
    for (int i = 6; i < 10; i++) imem[i] = W_END;
    build_model(800);
    do_reset();
    run(150, 0, 1'b0, 0);
    check("overflow_err", loop_err, 1'b1);

    // Reset asserted during iteration 2 of a counted loop
    load_default();
    imem[13] = W_LOOP4;
    imem[30] = W_END;
    build_model(600);
    do_reset();
    run(200, 0, 1'b0, 2);
    check("midloop_reached", seen_red, 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_ex_valid", ex_valid, 1'b0);
    check("async_rst_ex_instr", ex_instr, 32'h0);
    check("async_rst_ex_pc", ex_pc, 16'h0);
    check("async_rst_Loop", Loop, 1'b0);
    check("async_rst_PC_in", PC_in, 16'h0);
    load_default();
    imem[0] = W_END;
    build_model(400);
    do_reset();
    run(12, 0, 1'b0, 0);
    check("post_rst_err", loop_err, 1'b1);
    check("post_rst_redirects", seen_red, 0);

    // Random programs with random execute back-pressure
    for (int p = 0; p < 4; p++) begin
      load_random();
      build_model(3000);
      do_reset();
      run(500, 25, 1'b0, 0);
      check("random_progress", (n_emit > 0), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
